// File: rtl/cpu_port_pkg.sv
// Shared C1 bus constants and cache request types for the CPU port and cache core.
package cpu_port_pkg;

  localparam int BITS_IN_BYTE      = 8;
  localparam int ADDR1_BUS_SIZE    = 2;
  localparam int DATA1_BUS_SIZE    = 2;
  localparam int ADDR_W            = ADDR1_BUS_SIZE * BITS_IN_BYTE;
  localparam int DATA_W            = DATA1_BUS_SIZE * BITS_IN_BYTE;
  localparam int CACHE_TAG_SIZE    = 10;
  localparam int CACHE_SET_SIZE    = 5;
  localparam int CACHE_OFFSET_SIZE = 4;
  localparam int LINE_BYTES        = 1 << CACHE_OFFSET_SIZE;

  typedef logic [2:0] c1_cmd_t;

  localparam c1_cmd_t C1_NOP             = 3'd0;
  localparam c1_cmd_t C1_READ8           = 3'd1;
  localparam c1_cmd_t C1_READ16          = 3'd2;
  localparam c1_cmd_t C1_READ32          = 3'd3;
  localparam c1_cmd_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_cmd_t C1_WRITE8          = 3'd5;
  localparam c1_cmd_t C1_WRITE16         = 3'd6;
  localparam c1_cmd_t C1_WRITE32         = 3'd7;
  localparam c1_cmd_t C1_RESPONSE        = 3'd7;

  typedef struct packed {
    logic [CACHE_TAG_SIZE-1:0]    tag;
    logic [CACHE_SET_SIZE-1:0]    set;
    logic [CACHE_OFFSET_SIZE-1:0] offset;
  } cache_addr_t;

  typedef struct packed {
    c1_cmd_t     cmd;
    cache_addr_t addr;
    logic [31:0] wdata;
  } cpu_req_t;

  // Bytes moved by a read/write, taken from the low command bits.
  function automatic logic [CACHE_OFFSET_SIZE:0] c1_bytes(input c1_cmd_t cmd);
    case (cmd[1:0])
      2'd1:    c1_bytes = 5'd1;
      2'd2:    c1_bytes = 5'd2;
      2'd3:    c1_bytes = 5'd4;
      default: c1_bytes = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_port_if.sv
// Request/response channel between the CPU port (master) and the cache core (slave).
interface cpu_port_if;
  import cpu_port_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  c1_cmd_t                      req_cmd;
  logic [CACHE_TAG_SIZE-1:0]    req_tag;
  logic [CACHE_SET_SIZE-1:0]    req_set;
  logic [CACHE_OFFSET_SIZE-1:0] req_offset;
  logic [31:0]                  req_wdata;
  logic                         rsp_valid;
  logic [31:0]                  rsp_rdata;
  logic                         err;

  modport master (
    output req_valid, req_cmd, req_tag, req_set, req_offset, req_wdata, err,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_tag, req_set, req_offset, req_wdata, err,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/cpu_port.sv
// C1 CPU bus front end: deserialises a CPU command into one cache request and
// serialises the core's answer back onto the shared bus as C1_RESPONSE.
module cpu_port
  import cpu_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_cpu_w,
  inout  wire  [DATA_W-1:0] data_cpu_w,
  inout  wire  [2:0]        cmd_cpu_w,
  cpu_port_if.master        core
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR2, S_DATA2, S_CHECK, S_REQ, S_WAIT, S_RESP, S_RESP2
  } state_t;

  state_t            r_state;
  cpu_req_t          r_req;
  logic              r_req_valid;
  logic              r_err;
  logic              r_own;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_rdata_hi;

  logic w_is_write;
  logic w_is_read;
  logic w_cross;
  logic w_unused;

  assign w_is_write = r_req.cmd[2] && (r_req.cmd[1:0] != 2'd0);
  assign w_is_read  = !r_req.cmd[2] && (r_req.cmd[1:0] != 2'd0);
  assign w_cross    = (w_is_read || w_is_write) &&
                      (({1'b0, r_req.addr.offset} + c1_bytes(r_req.cmd)) > 5'(LINE_BYTES));
  assign w_unused   = addr_cpu_w[ADDR_W-1];

  // The bus is only ever driven while this block owns it; reset drops ownership at once.
  assign data_cpu_w = r_own ? r_dout : 'z;
  assign cmd_cpu_w  = r_own ? C1_RESPONSE : 'z;

  assign core.req_valid  = r_req_valid;
  assign core.req_cmd    = r_req.cmd;
  assign core.req_tag    = r_req.addr.tag;
  assign core.req_set    = r_req.addr.set;
  assign core.req_offset = r_req.addr.offset;
  assign core.req_wdata  = r_req.wdata;
  assign core.err        = r_err;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_req_valid <= 1'b0;
      r_err       <= 1'b0;
      r_own       <= 1'b0;
      r_dout      <= '0;
      r_rdata_hi  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_cpu_w != C1_NOP) begin
            r_req.cmd                        <= cmd_cpu_w;
            {r_req.addr.tag, r_req.addr.set} <= addr_cpu_w[ADDR_W-2:0];
            r_req.addr.offset                <= '0;
            r_req.wdata                      <= '0;
            r_state                          <= S_ADDR2;
          end
        end
        S_ADDR2: begin
          r_req.addr.offset <= addr_cpu_w[CACHE_OFFSET_SIZE-1:0];
          if (w_is_write) begin
            r_req.wdata <= (r_req.cmd == C1_WRITE8) ? {24'd0, data_cpu_w[7:0]}
                                                    : {16'd0, data_cpu_w};
          end
          r_state <= (r_req.cmd == C1_WRITE32) ? S_DATA2 : S_CHECK;
        end
        S_DATA2: begin
          r_req.wdata[31:16] <= data_cpu_w;
          r_state            <= S_CHECK;
        end
        S_CHECK: begin
          if (w_cross) begin
            r_err      <= 1'b1;
            r_own      <= 1'b1;
            r_dout     <= '0;
            r_rdata_hi <= '0;
            r_state    <= S_RESP;
          end else begin
            r_state <= S_REQ;
          end
        end
        // First REQ cycle raises valid; it then holds until the core accepts.
        S_REQ: begin
          if (!r_req_valid) begin
            r_req_valid <= 1'b1;
          end else if (core.req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core.rsp_valid) begin
            r_own      <= 1'b1;
            r_dout     <= w_is_read ? core.rsp_rdata[15:0] : '0;
            r_rdata_hi <= w_is_read ? core.rsp_rdata[31:16] : '0;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_req.cmd == C1_READ32) begin
            r_dout  <= r_rdata_hi;
            r_state <= S_RESP2;
          end else begin
            r_own   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RESP2: begin
          r_own   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_port.md
# cpu_port

CPU-side bus front end for the cache, placed between the CPU bus (addr_cpu_w / data_cpu_w / cmd_cpu_w) and the cache core.
- Deserialises the multi-cycle C1 protocol into one parallel request: command, tag/set/offset, up to 32 bits of write data.
- Hands that request to the cache core over a valid/ready handshake.
- Takes the core's response, takes ownership of the shared bus and serialises C1_RESPONSE back to the CPU.
- The cache core itself never touches the CPU bus.

## Interface
Parameters:
- cache_tag_size, 10, tag bits in the first address word
- cache_set_size, 5, set bits in the first address word
- cache_offset_size, 4, byte offset bits in the second address word
- addr1_bus_size / data1_bus_size, 2 / 2 bytes, CPU bus widths (from parameters.sv)

Ports:
- clk  in  1  single clock; all state updates on negedge clk (CPU drives on posedge)
- reset  in  1  asynchronous, active-low
- addr_cpu_w  in  16  CPU address bus
- data_cpu_w  inout  16  CPU data bus; driven only while the block owns the bus, else Z
- cmd_cpu_w  inout  3  C1 command bus; driven only while the block owns the bus, else Z
- req_valid  out  1  request to cache core
- req_ready  in  1  core accepts request
- req_cmd  out  3  latched C1 command
- req_tag / req_set / req_offset  out  10/5/4  decoded address
- req_wdata  out  32  write data, zero-extended
- rsp_valid  in  1  core result ready (single-cycle pulse)
- rsp_rdata  in  32  read data, right-aligned
- err  out  1  one-cycle pulse on a rejected (line-crossing) request

## Operation
C1 codes: NOP=0, READ8/16/32=1/2/3, INVALIDATE_LINE=4, WRITE8/16/32=5/6/7, RESPONSE=7. Byte count is taken from cmd[1:0]: 1→1 byte, 2→2 bytes, 3→4 bytes.

States:
- IDLE
  - Bus released.
  - Any non-NOP cmd sampled: latch cmd; {tag,set} = addr_cpu_w[14:0]; go to ADDR2.
- ADDR2
  - offset = addr_cpu_w[3:0].
  - On a write, wdata[15:0] = data_cpu_w (WRITE8 keeps only [7:0]).
  - WRITE32 → DATA2; otherwise → CHECK.
- DATA2
  - wdata[31:16] = data_cpu_w; → CHECK.
- CHECK
  - For read/write: if offset + bytes > 16, pulse err and go to RESP with response data 0.
  - Otherwise → REQ.
- REQ
  - req_valid=1 and all req_* held stable.
  - req_ready sampled 1 → WAIT.
- WAIT
  - rsp_valid sampled 1: latch rsp_rdata; → RESP.
- RESP
  - Own the bus: cmd_cpu_w=RESPONSE, data_cpu_w=rdata[15:0].
  - READ32 → RESP2; otherwise → IDLE.
- RESP2
  - data_cpu_w=rdata[31:16]; → IDLE.

Command-specific rules:
- Writes and INVALIDATE_LINE get a single RESPONSE cycle with data 0.
- INVALIDATE_LINE ignores the offset and never raises err.

Boundaries:
- CPU cmd activity outside IDLE is ignored.
- rsp_valid outside WAIT is ignored.
- Reset at any point:
  - state→IDLE; pending transaction discarded.
  - data/cmd buses released (Z) immediately.
  - req_valid=0, err=0, req_* and wdata cleared to 0.
- No wrap-around: a line-crossing request is always rejected, never split.

## Timing
- N = first negedge seeing a command. Offset/data0 captured at N+1; data1 at N+2 (WRITE32 only).
- CHECK occupies one cycle. req_valid rises at the negedge after CHECK: N+3, or N+4 for WRITE32.
- Handshake completes at the first negedge where req_valid && req_ready.
- Response drive starts at the negedge after rsp_valid is sampled, so the CPU sees RESPONSE at the following posedge.
- Bus released at the negedge ending the last RESP cycle. A new command is accepted no earlier than the next negedge.
- Minimum READ8 round trip, with req_ready=1 and rsp_valid one cycle after the handshake: RESPONSE visible 6 cycles after N.

## Structure
- parameters.sv holds the C1_* constants, bus sizes and BITS_IN_BYTE.
- The shared package also holds the cacheAddr typedef (tag/set/offset) and a cpu_req_t packed struct (cmd, addr, wdata), reused by the cache core.
- State enum stays local.
- No sub-module; tristates are continuous assigns gated by an owner flag.

## Test plan
- WRITE32: addr 16'h019B, then 16'h0002, data 16'hAAAA, 16'hFF00 → req tag=12, set=27, offset=2, wdata=32'hFF00AAAA, cmd=7; one RESPONSE cycle.
- READ32 at offset 4; core returns 32'h12345678 → RESPONSE with 16'h5678, then 16'h1234; bus Z afterwards.
- READ16 at offset 15 → err pulse, no req_valid, RESPONSE data 0.
- req_ready held low 5 cycles → req_valid and all req_* stable throughout; exactly one accepted request.
- Reset asserted in WAIT → buses Z and req_valid=0 immediately; a subsequent rsp_valid is ignored; a new WRITE8 of 8'h99 at offset 0 is processed normally.
